// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Start/busy/done handshake, optional two's-complement input, sticky overflow.
module bcd_seq_converter #(
  parameter int unsigned WIDTH     = 13,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SIGNED_EN = 0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [WIDTH-1:0]    num_i,
  input  logic                signed_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                neg_o,
  output logic                overflow_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BcdW-1:0]   dig_q, dig_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              ovf_q, ovf_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic              ovf_out_q, ovf_out_d;
  logic              done_q, done_d;

  logic              mag_neg;
  logic [WIDTH-1:0]  mag;
  logic [BcdW-1:0]   adj;
  logic [BcdW-1:0]   dig_nx;
  logic              ovf_bit;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the
  // correct magnitude when read as unsigned.
  assign mag_neg = (SIGNED_EN != 0) && signed_i && num_i[WIDTH-1];
  assign mag     = mag_neg ? -num_i : num_i;

  always_comb begin
    adj = dig_q;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k+:4] >= 4'd5) begin
        adj[4*k+:4] = dig_q[4*k+:4] + 4'd3;
      end
    end
  end

  assign dig_nx  = {adj[BcdW-2:0], shift_q[WIDTH-1]};
  assign ovf_bit = adj[BcdW-1];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_out_d = ovf_out_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StConv;
          shift_d = mag;
          dig_d   = '0;
          cnt_d   = '0;
          sign_d  = mag_neg;
          ovf_d   = 1'b0;
        end
      end
      StConv: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        dig_d   = dig_nx;
        ovf_d   = ovf_q | ovf_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d   = StIdle;
          bcd_d     = dig_nx;
          neg_d     = sign_q;
          ovf_out_d = ovf_q | ovf_bit;
          done_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_out_q <= ovf_out_d;
      done_q    <= done_d;
    end
  end

  assign busy_o     = (state_q == StConv);
  assign done_o     = done_q;
  assign bcd_o      = bcd_q;
  assign neg_o      = neg_q;
  assign overflow_o = ovf_out_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: default, 3-digit and signed instances
// share one stimulus stream; table vectors plus handshake/reset sequences.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [12:0] num = '0;

  logic        busy0, done0, neg0, ovf0;
  logic [15:0] bcd0;
  logic        busy1, done1, neg1, ovf1;
  logic [11:0] bcd1;
  logic        busy2, done2, neg2, ovf2;
  logic [15:0] bcd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(13), .DIGITS(4), .SIGNED_EN(0)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .num_i(num), .signed_i(sgn),
    .busy_o(busy0), .done_o(done0), .bcd_o(bcd0), .neg_o(neg0), .overflow_o(ovf0)
  );

  bcd_seq_converter #(.WIDTH(13), .DIGITS(3), .SIGNED_EN(0)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .num_i(num), .signed_i(sgn),
    .busy_o(busy1), .done_o(done1), .bcd_o(bcd1), .neg_o(neg1), .overflow_o(ovf1)
  );

  bcd_seq_converter #(.WIDTH(13), .DIGITS(4), .SIGNED_EN(1)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .num_i(num), .signed_i(sgn),
    .busy_o(busy2), .done_o(done2), .bcd_o(bcd2), .neg_o(neg2), .overflow_o(ovf2)
  );

  typedef struct {
    logic [12:0] num;
    logic        s;
    logic [15:0] b0;
    logic [11:0] b1;
    logic        o1;
    logic [15:0] b2;
    logic        n2;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic kick(input logic [12:0] n, input logic s);
    start = 1'b1;
    num   = n;
    sgn   = s;
  endtask

  // Counts negedges after the accepting edge until done0; lat = -1 on timeout.
  // At negedge evt_at, num is replaced and start driven with evt_start.
  task automatic wait_done(input int evt_at, input logic [12:0] evt_num,
                           input logic evt_start, output int lat, output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == evt_at) begin
        num   = evt_num;
        start = evt_start;
      end
      if (done0) begin
        lat = i;
        break;
      end
      if (busy0) busy_n++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int bn;
    logic seen;

    tv[0] = '{13'd4095,  1'b0, 16'h4095, 12'h095, 1'b1, 16'h4095, 1'b0};
    tv[1] = '{13'd8191,  1'b0, 16'h8191, 12'h191, 1'b1, 16'h8191, 1'b0};
    tv[2] = '{13'h1FFF,  1'b1, 16'h8191, 12'h191, 1'b1, 16'h0001, 1'b1};
    tv[3] = '{13'h1000,  1'b1, 16'h4096, 12'h096, 1'b1, 16'h4096, 1'b1};
    tv[4] = '{13'd999,   1'b0, 16'h0999, 12'h999, 1'b0, 16'h0999, 1'b0};
    tv[5] = '{13'd1000,  1'b0, 16'h1000, 12'h000, 1'b1, 16'h1000, 1'b0};
    tv[6] = '{13'd0,     1'b1, 16'h0000, 12'h000, 1'b0, 16'h0000, 1'b0};
    tv[7] = '{13'd12,    1'b1, 16'h0012, 12'h012, 1'b0, 16'h0012, 1'b0};
    tv[8] = '{13'h1F9C,  1'b1, 16'h8092, 12'h092, 1'b1, 16'h0100, 1'b1};
    tv[9] = '{13'd1,     1'b0, 16'h0001, 12'h001, 1'b0, 16'h0001, 1'b0};

    #3;
    chk("reset bcd0", bcd0, 0);
    chk("reset busy/done/neg/ovf", {busy0, done0, neg0, ovf0}, 0);
    chk("reset u1/u2 outs", {bcd1, bcd2, busy1, busy2, ovf1, neg2}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      kick(tv[i].num, tv[i].s);
      wait_done(0, '0, 1'b0, lat, bn);
      chk($sformatf("v%0d latency", i), lat, 14);
      chk($sformatf("v%0d busy cycles", i), bn, 13);
      chk($sformatf("v%0d bcd0", i), bcd0, tv[i].b0);
      chk($sformatf("v%0d neg0/ovf0", i), {neg0, ovf0}, 0);
      chk($sformatf("v%0d bcd1", i), bcd1, tv[i].b1);
      chk($sformatf("v%0d ovf1", i), ovf1, tv[i].o1);
      chk($sformatf("v%0d bcd2", i), bcd2, tv[i].b2);
      chk($sformatf("v%0d neg2", i), neg2, tv[i].n2);
      chk($sformatf("v%0d ovf2", i), ovf2, 0);
      chk($sformatf("v%0d done u1/u2", i), {done1, done2}, 2'b11);
      chk($sformatf("v%0d busy in done cycle", i), busy0, 0);
      @(negedge clk);
      chk($sformatf("v%0d done one cycle", i), done0, 0);
    end

    // Start during CONV is ignored.
    @(negedge clk);
    kick(13'd12, 1'b0);
    wait_done(5, 13'd99, 1'b1, lat, bn);
    chk("ignored start latency", lat, 14);
    chk("ignored start bcd0", bcd0, 16'h0012);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    chk("ignored start not queued", seen, 0);

    // Back-to-back: start in the done cycle is accepted.
    @(negedge clk);
    kick(13'd12, 1'b0);
    wait_done(0, '0, 1'b0, lat, bn);
    chk("b2b first bcd0", bcd0, 16'h0012);
    kick(13'd99, 1'b0);
    wait_done(0, '0, 1'b0, lat, bn);
    chk("b2b second latency", lat, 14);
    chk("b2b second bcd0", bcd0, 16'h0099);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    kick(13'd1234, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold during conv bcd0", bcd0, 16'h0099);
    chk("busy before reset", busy0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset bcd0", bcd0, 0);
    chk("async reset flags", {busy0, done0, neg0, ovf0, busy2}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    chk("no done after abort", seen, 0);

    @(negedge clk);
    kick(13'd0, 1'b1);
    wait_done(0, '0, 1'b0, lat, bn);
    chk("zero latency", lat, 14);
    chk("zero bcd0/bcd2", {bcd0, bcd2}, 0);
    chk("zero neg0/neg2", {neg0, neg2}, 0);
    @(negedge clk);
    chk("zero done once", done0, 0);

    // num_i change after acceptance has no effect.
    @(negedge clk);
    kick(13'd777, 1'b0);
    wait_done(1, 13'd5, 1'b0, lat, bn);
    chk("capture latency", lat, 14);
    chk("capture bcd0", bcd0, 16'h0777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
